// File: rtl/twiddle_table_loader.sv
// twiddle_table_loader: loadable DFT twiddle-factor table with
// size-scaled lookup (k << (LOG_N_MAX - log_n)) mod N_MAX.
//
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_wr_start             restart table load at address 0
//   i_wr_valid/o_wr_ready  load handshake, data i_wr_re/i_wr_im
//   o_loaded               whole table written, lookups enabled
//   i_rd_valid/o_rd_ready  lookup handshake, i_rd_index/i_rd_log_n
//   o_rd_valid             o_c_re/o_c_im carry a lookup result
//   o_err                  sticky protocol error

module twiddle_table_loader #(
  parameter int WIDTH     = 12,
  parameter int LOG_N_MAX = 10,
  parameter int N_MAX     = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_start,
  input  logic                    i_wr_valid,
  input  logic signed [WIDTH-1:0] i_wr_re,
  input  logic signed [WIDTH-1:0] i_wr_im,
  output logic                    o_wr_ready,
  output logic                    o_loaded,
  input  logic                    i_rd_valid,
  input  logic        [WIDTH-1:0] i_rd_index,
  input  logic        [WIDTH-1:0] i_rd_log_n,
  output logic                    o_rd_ready,
  output logic                    o_rd_valid,
  output logic signed [WIDTH-1:0] o_c_re,
  output logic signed [WIDTH-1:0] o_c_im,
  output logic                    o_err
);

  localparam int AW = LOG_N_MAX;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] ptr_q, ptr_d;
  logic          loaded_q, loaded_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;

  logic signed [WIDTH-1:0] c_re_q, c_re_d;
  logic signed [WIDTH-1:0] c_im_q, c_im_d;

  logic signed [WIDTH-1:0] mem_re [N_MAX];
  logic signed [WIDTH-1:0] mem_im [N_MAX];

  logic             wr_fire;
  logic             ptr_last;
  logic             rd_fire;
  logic             rd_bad;
  logic [WIDTH-1:0] rd_shamt;
  logic [AW-1:0]    rd_addr;

  // Ready is forced low during reset so no load can be
  // counted against a pointer that is being cleared.
  assign o_wr_ready = i_rst_n
                    & (state_q == ST_LOAD)
                    & ~i_wr_start;

  assign wr_fire  = o_wr_ready & i_wr_valid;
  assign ptr_last = (ptr_q == AW'(N_MAX - 1));

  assign o_rd_ready = loaded_q;
  assign rd_fire    = i_rd_valid & loaded_q;
  assign rd_bad     = (i_rd_log_n > WIDTH'(LOG_N_MAX));

  // Smaller DFTs stride through the full-size table; bits
  // shifted past the address width are simply dropped.
  assign rd_shamt = WIDTH'(LOG_N_MAX) - i_rd_log_n;
  assign rd_addr  = AW'(i_rd_index << rd_shamt);

  // Table contents survive reset on purpose.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem_re[ptr_q] <= i_wr_re;
      mem_im[ptr_q] <= i_wr_im;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_LOAD;
      ptr_q      <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      c_re_q     <= '0;
      c_im_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      c_re_q     <= c_re_d;
      c_im_q     <= c_im_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    loaded_d   = loaded_q;
    err_d      = err_q;
    rd_valid_d = rd_fire;
    c_re_d     = c_re_q;
    c_im_d     = c_im_q;

    case (state_q)
      ST_LOAD: begin
        if (wr_fire) begin
          ptr_d = ptr_q + AW'(1);
          if (ptr_last) begin
            state_d  = ST_READY;
            loaded_d = 1'b1;
          end
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      ST_HOLD: begin
        state_d  = ST_LOAD;
        loaded_d = 1'b0;
      end
      default: begin
        state_d  = ST_LOAD;
        loaded_d = 1'b0;
      end
    endcase

    if (rd_fire) begin
      if (rd_bad) begin
        c_re_d = '0;
        c_im_d = '0;
        err_d  = 1'b1;
      end else begin
        c_re_d = mem_re[rd_addr];
        c_im_d = mem_im[rd_addr];
      end
    end

    if (i_rd_valid && !loaded_q) begin
      err_d = 1'b1;
    end

    // Restart wins over everything except a lookup already
    // accepted this cycle, which still returns its data.
    if (i_wr_start) begin
      state_d  = ST_LOAD;
      ptr_d    = '0;
      loaded_d = 1'b0;
      err_d    = 1'b0;
    end
  end

  assign o_loaded   = loaded_q;
  assign o_rd_valid = rd_valid_q;
  assign o_c_re     = c_re_q;
  assign o_c_im     = c_im_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_twiddle_table_loader.sv
// tb_twiddle_table_loader: randomized checks of twiddle_table_loader
// against an array/arithmetic reference model.

module tb_twiddle_table_loader;

  localparam int W = 12;
  localparam int L = 10;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr_start = 1'b0;
  logic wr_valid = 1'b0;
  logic rd_valid = 1'b0;
  logic [W-1:0] wr_re = '0;
  logic [W-1:0] wr_im = '0;
  logic [W-1:0] rd_index = '0;
  logic [W-1:0] rd_log_n = '0;

  logic wr_ready, loaded, rd_ready, rdv, err;
  logic [W-1:0] c_re, c_im;

  int asserts = 0;
  int fails = 0;

  logic [W-1:0] m_re [N];
  logic [W-1:0] m_im [N];
  int m_ptr = 0;
  bit m_loaded = 1'b0;
  bit m_err = 1'b0;

  int q_idx[$];
  int q_log[$];

  always #5 clk = ~clk;

  twiddle_table_loader #(
    .WIDTH(W), .LOG_N_MAX(L), .N_MAX(N)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_wr_start(wr_start),
    .i_wr_valid(wr_valid),
    .i_wr_re(wr_re),
    .i_wr_im(wr_im),
    .o_wr_ready(wr_ready),
    .o_loaded(loaded),
    .i_rd_valid(rd_valid),
    .i_rd_index(rd_index),
    .i_rd_log_n(rd_log_n),
    .o_rd_ready(rd_ready),
    .o_rd_valid(rdv),
    .o_c_re(c_re),
    .o_c_im(c_im),
    .o_err(err)
  );

  function automatic logic [W-1:0] exp_re(input int idx, input int lg);
    if (lg > L) return '0;
    return m_re[(idx * (1 << (L - lg))) % N];
  endfunction

  function automatic logic [W-1:0] exp_im(input int idx, input int lg);
    if (lg > L) return '0;
    return m_im[(idx * (1 << (L - lg))) % N];
  endfunction

  task automatic load_pairs(input int count, input int mode, input bit gaps);
    int acc = 0;
    int cyc = 0;
    logic [W-1:0] re, im;
    while (acc < count && cyc < 4 * count + 16) begin
      @(negedge clk); #1;
      cyc++;
      wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      re = (mode == 0) ? W'(m_ptr) : W'(2 * m_ptr);
      im = (mode == 0) ? W'(-m_ptr) : W'($urandom);
      wr_re = re;
      wr_im = im;
      #1;
      asserts++;
      if (wr_ready !== 1'b1) begin
        fails++;
        $display("FAIL load_ready ptr=%0d: got %b expected 1", m_ptr, wr_ready);
      end
      asserts++;
      if (loaded !== m_loaded) begin
        fails++;
        $display("FAIL load_loaded ptr=%0d: got %b expected %b", m_ptr, loaded, m_loaded);
      end
      if (wr_valid && wr_ready) begin
        m_re[m_ptr] = re;
        m_im[m_ptr] = im;
        acc++;
        m_ptr++;
        if (m_ptr == N) begin
          m_ptr = 0;
          m_loaded = 1'b1;
        end
      end
    end
    asserts++;
    if (acc != count) begin
      fails++;
      $display("FAIL load_count: got %0d accepts expected %0d", acc, count);
    end
  endtask

  task automatic run_stream(input string name);
    int n = q_idx.size();
    bit pend = 1'b0;
    logic [W-1:0] er = '0;
    logic [W-1:0] ei = '0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk); #1;
      if (pend) begin
        asserts++;
        if (rdv !== 1'b1 || c_re !== er || c_im !== ei) begin
          fails++;
          $display("FAIL %s result %0d: valid=%b re=%h im=%h expected valid=1 re=%h im=%h",
                   name, i - 1, rdv, c_re, c_im, er, ei);
        end
        asserts++;
        if (err !== m_err) begin
          fails++;
          $display("FAIL %s err %0d: got %b expected %b", name, i - 1, err, m_err);
        end
      end
      if (i < n) begin
        asserts++;
        if (rd_ready !== 1'b1) begin
          fails++;
          $display("FAIL %s rd_ready: got %b expected 1", name, rd_ready);
        end
        rd_valid = 1'b1;
        rd_index = W'(q_idx[i]);
        rd_log_n = W'(q_log[i]);
        er = exp_re(q_idx[i], q_log[i]);
        ei = exp_im(q_idx[i], q_log[i]);
        if (q_log[i] > L) m_err = 1'b1;
        pend = 1'b1;
      end else begin
        rd_valid = 1'b0;
        pend = 1'b0;
      end
    end
    @(negedge clk); #1;
    asserts++;
    if (rdv !== 1'b0 || c_re !== er || c_im !== ei) begin
      fails++;
      $display("FAIL %s idle_hold: valid=%b re=%h im=%h expected valid=0 re=%h im=%h",
               name, rdv, c_re, c_im, er, ei);
    end
    q_idx.delete();
    q_log.delete();
  endtask

  task automatic push_random(input int n, input bit allow_bad);
    for (int i = 0; i < n; i++) begin
      q_idx.push_back(int'($urandom_range(0, 4095)));
      if (allow_bad && $urandom_range(0, 7) == 0)
        q_log.push_back(int'($urandom_range(11, 4095)));
      else
        q_log.push_back(int'($urandom_range(0, 10)));
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    asserts++;
    if (wr_ready !== 1'b0 || loaded !== 1'b0 || rd_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: wr_ready=%b loaded=%b rd_ready=%b expected 0 0 0",
               wr_ready, loaded, rd_ready);
    end
    asserts++;
    if (rdv !== 1'b0 || err !== 1'b0 || c_re !== '0 || c_im !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdv=%b err=%b re=%h im=%h expected 0 0 0 0",
               rdv, err, c_re, c_im);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    asserts++;
    if (wr_ready !== 1'b1 || loaded !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: wr_ready=%b loaded=%b expected 1 0", wr_ready, loaded);
    end
    m_ptr = 0;
    m_loaded = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic test_load();
    load_pairs(N, 0, 1'b0);
    @(negedge clk); #1;
    asserts++;
    if (loaded !== 1'b1 || rd_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_done: loaded=%b rd_ready=%b expected 1 1", loaded, rd_ready);
    end
    asserts++;
    if (wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_ready_after: got %b expected 0", wr_ready);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_lookup();
    q_idx.push_back(5);
    q_log.push_back(10);
    run_stream("lookup_5");
    asserts++;
    if (c_re !== 12'd5 || c_im !== 12'hffb) begin
      fails++;
      $display("FAIL lookup_5_value: re=%h im=%h expected 005 ffb", c_re, c_im);
    end
    for (int i = 0; i < 3; i++) begin
      q_idx.push_back(i);
      q_log.push_back(10);
    end
    run_stream("lookup_012");
    push_random(200, 1'b0);
    run_stream("lookup_rand");
  endtask

  task automatic test_addr_map();
    q_idx = '{3, 9, 7, 1023, 4095};
    q_log = '{3, 3, 0, 10, 1};
    run_stream("addr_map");
    q_idx.push_back(3);
    q_log.push_back(3);
    run_stream("addr_384");
    asserts++;
    if (c_re !== 12'd384) begin
      fails++;
      $display("FAIL addr_384_value: re=%0d expected 384", c_re);
    end
  endtask

  task automatic test_bad_log_n();
    @(negedge clk); #1;
    asserts++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL bad_logn_pre: err=%b expected 0", err);
    end
    q_idx.push_back(5);
    q_log.push_back(11);
    run_stream("bad_logn");
    repeat (3) @(negedge clk);
    #1;
    asserts++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: err=%b expected 1", err);
    end
    push_random(150, 1'b1);
    run_stream("lookup_rand_bad");
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    wr_start = 1'b1;
    wr_valid = 1'b1;
    #1;
    asserts++;
    if (wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_ready: got %b expected 0", wr_ready);
    end
    m_ptr = 0;
    m_loaded = 1'b0;
    m_err = 1'b0;
    @(negedge clk); #1;
    wr_start = 1'b0;
    wr_valid = 1'b0;
    #1;
    asserts++;
    if (loaded !== 1'b0 || err !== 1'b0 || wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_state: loaded=%b err=%b wr_ready=%b expected 0 0 1",
               loaded, err, wr_ready);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    load_pairs(500, 1, 1'b1);
    @(negedge clk); #1;
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_index = W'(3);
    rd_log_n = W'(10);
    asserts++;
    if (rd_ready !== 1'b0) begin
      fails++;
      $display("FAIL early_rd_ready: got %b expected 0", rd_ready);
    end
    @(negedge clk); #1;
    rd_valid = 1'b0;
    asserts++;
    if (rdv !== 1'b0 || err !== 1'b1) begin
      fails++;
      $display("FAIL early_lookup: rdv=%b err=%b expected 0 1", rdv, err);
    end
    pulse_start();
    load_pairs(N, 1, 1'b1);
    @(negedge clk); #1;
    wr_valid = 1'b0;
    asserts++;
    if (loaded !== 1'b1) begin
      fails++;
      $display("FAIL reload_done: loaded=%b expected 1", loaded);
    end
    q_idx.push_back(3);
    q_log.push_back(10);
    run_stream("reload_3");
    asserts++;
    if (c_re !== 12'd6) begin
      fails++;
      $display("FAIL reload_3_value: re=%0d expected 6", c_re);
    end
    push_random(100, 1'b0);
    run_stream("reload_rand");
  endtask

  task automatic test_start_with_lookup();
    logic [W-1:0] er, ei;
    @(negedge clk); #1;
    rd_valid = 1'b1;
    rd_index = W'(7);
    rd_log_n = W'(10);
    wr_start = 1'b1;
    er = exp_re(7, 10);
    ei = exp_im(7, 10);
    m_ptr = 0;
    m_loaded = 1'b0;
    m_err = 1'b0;
    @(negedge clk); #1;
    rd_valid = 1'b0;
    wr_start = 1'b0;
    asserts++;
    if (rdv !== 1'b1 || c_re !== er || c_im !== ei) begin
      fails++;
      $display("FAIL start_lookup: rdv=%b re=%h im=%h expected 1 %h %h", rdv, c_re, c_im, er, ei);
    end
    asserts++;
    if (loaded !== 1'b0) begin
      fails++;
      $display("FAIL start_lookup_loaded: got %b expected 0", loaded);
    end
    @(negedge clk); #1;
    asserts++;
    if (rdv !== 1'b0) begin
      fails++;
      $display("FAIL start_lookup_once: rdv=%b expected 0", rdv);
    end
  endtask

  task automatic test_reset_mid_lookup();
    load_pairs(N, 0, 1'b0);
    @(negedge clk); #1;
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_index = W'(5);
    rd_log_n = W'(10);
    @(negedge clk); #1;
    rd_valid = 1'b0;
    asserts++;
    if (rdv !== 1'b1 || c_re !== 12'd5) begin
      fails++;
      $display("FAIL pre_reset_lookup: rdv=%b re=%0d expected 1 5", rdv, c_re);
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if (rdv !== 1'b0 || loaded !== 1'b0 || wr_ready !== 1'b0 || c_re !== '0) begin
      fails++;
      $display("FAIL mid_reset: rdv=%b loaded=%b wr_ready=%b re=%h expected 0 0 0 000",
               rdv, loaded, wr_ready, c_re);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    m_ptr = 0;
    m_loaded = 1'b0;
    m_err = 1'b0;
    #1;
    asserts++;
    if (wr_ready !== 1'b1 || rdv !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: wr_ready=%b rdv=%b expected 1 0", wr_ready, rdv);
    end
    @(negedge clk); #1;
    asserts++;
    if (rdv !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_pulse: rdv=%b expected 0", rdv);
    end
    load_pairs(N, 0, 1'b1);
    @(negedge clk); #1;
    wr_valid = 1'b0;
    push_random(150, 1'b0);
    run_stream("identical_reload");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_lookup();
    test_addr_map();
    test_bad_log_n();
    test_restart();
    test_start_with_lookup();
    test_reset_mid_lookup();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
